dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter: ADDR_W, default 32, width of byte address on both sides.
REQ-002 SHALL have ports: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have ports: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: cpu_req  input  1  M-stage memory access valid (load or store).
REQ-005 SHALL have ports: cpu_wr  input  1  1=store, 0=load.
REQ-006 SHALL have ports: cpu_size  input  2  0=byte, 1=half, 2=word; 3 is illegal and treated as word.
REQ-007 SHALL have ports: cpu_addr  input  ADDR_W  byte address (aluoutM).
REQ-008 SHALL have ports: cpu_wdata  input  32  store data (writedataM), right-aligned.
REQ-009 SHALL have ports: pipe_adv  input  1  M stage advances to W this cycle.
REQ-010 SHALL have ports: cpu_rdata  output  32  raw load word, valid while state DONE.
REQ-011 SHALL have ports: cpu_stall  output  1  stall request to the hazard unit.
REQ-012 SHALL have ports: cpu_adel, cpu_ades  output  1 each  load/store misalignment flags.
REQ-013 SHALL have ports: data_req, data_wr  output  1 each  bus request, bus write.
REQ-014 SHALL have ports: data_size  output  2  bus size (copy of cpu_size).
REQ-015 SHALL have ports: data_addr  output  ADDR_W  bus address.
REQ-016 SHALL have ports: data_wdata  output  32  bus write data.
REQ-017 SHALL have ports: data_addr_ok, data_data_ok  input  1 each  request accepted, data phase done.
REQ-018 SHALL have ports: data_rdata  input  32  bus read data, valid with data_data_ok.

Function
REQ-019 SHALL implement FSM IDLE, REQ, WAIT, DONE; exactly one state at a time.
REQ-020 IDLE: cpu_req=1 and no misalignment flag -> REQ; latch cpu_wr, cpu_size, cpu_addr and the replicated wdata into request registers.
REQ-021 REQ: data_req=1 with the latched fields held stable; addr_ok=1 and data_ok=0 -> WAIT; addr_ok=1 and data_ok=1 in the same cycle -> DONE.
REQ-022 WAIT: data_req=0; data_ok=1 -> DONE.
REQ-023 In REQ or WAIT, every transition into DONE SHALL capture data_rdata into cpu_rdata; stores also capture it, and the captured value is don't-care for stores.
REQ-024 DONE: pipe_adv=1 -> IDLE; otherwise hold state and cpu_rdata, and issue no new request.
REQ-025 data_ok in IDLE, or in REQ with addr_ok=0, SHALL be ignored.
REQ-026 pipe_adv SHALL be ignored in IDLE, REQ and WAIT.
REQ-027 cpu_stall = cpu_req & (state != DONE) & ~(cpu_adel | cpu_ades); combinational.
REQ-028 Minimum stall for a hit with same-cycle addr_ok/data_ok: 2 cycles (IDLE, REQ).
REQ-029 Write-data replication: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> unchanged.
REQ-030 data_wr, data_size and data_addr SHALL be driven from the request registers, never directly from the cpu_* inputs.

Reset
REQ-031 rst low SHALL force IDLE immediately, clear all request registers and cpu_rdata to 0, and drive data_req=0, cpu_stall=0, cpu_adel=0, cpu_ades=0.
REQ-032 A transaction in flight when rst is asserted SHALL be abandoned, and any late data_ok after rst deasserts SHALL be ignored per REQ-025.

Configuration
REQ-033 Macro DMEM_BRIDGE_ALIGN_CHECK_EN defined: in IDLE, cpu_adel = cpu_req & ~cpu_wr & misaligned and cpu_ades = cpu_req & cpu_wr & misaligned, where misaligned is (half & addr[0]) or (word & addr[1:0]!=0); on a misaligned access the FSM stays in IDLE and no bus request is issued.
REQ-034 Macro DMEM_BRIDGE_ALIGN_CHECK_EN undefined: cpu_adel=cpu_ades=0 constant, and every cpu_req is issued to the bus unchecked.

Verification
REQ-035 Bench SHALL cover: word load addr 0x100; addr_ok and data_ok in the REQ cycle with rdata 0xDEADBEEF -> stall for 2 cycles, cpu_rdata=0xDEADBEEF in DONE, IDLE after pipe_adv.
REQ-036 Bench SHALL cover: byte store wdata 0x000000A5 addr 0x203 -> data_wdata=0xA5A5A5A5, data_size=0, data_wr=1, data_addr=0x203.
REQ-037 Bench SHALL cover: addr_ok delayed 3 cycles and data_ok 2 cycles later -> data_req high for exactly 4 cycles, stall for 7 cycles, one transaction only.
REQ-038 Bench SHALL cover: DONE held 5 cycles with pipe_adv=0 and cpu_req=1 -> no second data_req, and cpu_rdata stable.
REQ-039 Bench SHALL cover: rst pulse while in WAIT, followed by a stray data_ok -> IDLE, all outputs 0, stray data_ok ignored.
REQ-040 Bench SHALL cover: word load addr 0x102 with the macro defined -> cpu_adel=1, cpu_stall=0, data_req=0; without the macro -> normal bus request with addr 0x102.

Source files
------------

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - M-stage data memory bridge onto a request/addr_ok/data_ok bus
//
// Purpose:
//   Turns one M-stage load/store into one bus transaction. It stalls the
//   pipeline until the data phase completes, then holds the result until the
//   pipeline advances.
//   Optional macro: DMEM_BRIDGE_ALIGN_CHECK_EN enables misalignment detection.
//   When it is enabled, a misaligned access raises cpu_adel/cpu_ades and is
//   never issued to the bus.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   cpu_req/wr/size/addr/wdata, pipe_adv      M-stage access and advance
//   cpu_rdata, cpu_stall, cpu_adel, cpu_ades  result, stall, misalign flags
//   data_req/wr/size/addr/wdata               bus request (from request regs)
//   data_addr_ok, data_data_ok, data_rdata    bus handshake and read data
module dmem_bridge #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [1:0]        cpu_size,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic              pipe_adv,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   output logic              cpu_adel,
   output logic              cpu_ades,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [31:0]       data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [31:0]       data_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t            r_state;
   logic              r_wr;
   logic [1:0]        r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rdata;

   logic [31:0]       w_wdata_rep;
   logic              w_adel;
   logic              w_ades;

   // Lane replication lets the memory pick its byte/half lanes from any slot.
   always_comb begin
      w_wdata_rep = cpu_wdata;
      case (cpu_size)
         2'd0:    w_wdata_rep = {4{cpu_wdata[7:0]}};
         2'd1:    w_wdata_rep = {2{cpu_wdata[15:0]}};
         default: w_wdata_rep = cpu_wdata;
      endcase
   end

`ifdef DMEM_BRIDGE_ALIGN_CHECK_EN
   logic w_misaligned;

   // Size 3 is treated as a word access.
   always_comb begin
      w_misaligned = 1'b0;
      if (cpu_size == 2'd1)
         w_misaligned = cpu_addr[0];
      else if (cpu_size[1])
         w_misaligned = |cpu_addr[1:0];
   end

   // The flags are qualified by rst so that they read 0 while reset is held.
   assign w_adel = rst & (r_state == S_IDLE) & cpu_req & ~cpu_wr & w_misaligned;
   assign w_ades = rst & (r_state == S_IDLE) & cpu_req &  cpu_wr & w_misaligned;
`else
   assign w_adel = 1'b0;
   assign w_ades = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_wr    <= 1'b0;
         r_size  <= 2'd0;
         r_addr  <= '0;
         r_wdata <= 32'd0;
         r_rdata <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cpu_req && !(w_adel || w_ades)) begin
                  r_state <= S_REQ;
                  r_wr    <= cpu_wr;
                  r_size  <= cpu_size;
                  r_addr  <= cpu_addr;
                  r_wdata <= w_wdata_rep;
               end
            end
            S_REQ: begin
               // data_ok is ignored here unless addr_ok is also high.
               if (data_addr_ok) begin
                  if (data_data_ok) begin
                     r_state <= S_DONE;
                     r_rdata <= data_rdata;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (data_data_ok) begin
                  r_state <= S_DONE;
                  r_rdata <= data_rdata;
               end
            end
            S_DONE: begin
               if (pipe_adv)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign data_req   = (r_state == S_REQ);
   assign data_wr    = r_wr;
   assign data_size  = r_size;
   assign data_addr  = r_addr;
   assign data_wdata = r_wdata;
   assign cpu_rdata  = r_rdata;
   assign cpu_adel   = w_adel;
   assign cpu_ades   = w_ades;
   // Also qualified by rst, so that the stall reads 0 while reset is held.
   assign cpu_stall  = rst & cpu_req & (r_state != S_DONE) & ~(w_adel | w_ades);

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - self-checking bench for dmem_bridge
module tb_dmem_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_wr, pipe_adv;
   logic [1:0]  cpu_size;
   logic [31:0] cpu_addr, cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall, cpu_adel, cpu_ades;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;

   dmem_bridge #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .pipe_adv(pipe_adv),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .cpu_adel(cpu_adel), .cpu_ades(cpu_ades),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        st;
      logic [31:0] rdata;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [31:0] exp_wdata;
   } vec_t;
   vec_t vecs[7];

   int          o_stall, o_reqc;
   logic [31:0] o_addr, o_wdata;
   logic [1:0]  o_size;
   logic        o_wr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Runs one access from IDLE to DONE; the bus answers addr_ok after a_dly
   // REQ cycles and data_ok d_dly cycles after that (0 = same cycle).
   task automatic txn(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata,
                      input int a_dly, input int d_dly);
      int  reqc, waitc;
      bit  accepted, done, first_req;
      sb_t e;
      reqc = 0; waitc = 0; accepted = 0; done = 0; first_req = 1;
      o_stall = 0; o_reqc = 0;
      o_addr = 32'hX; o_wdata = 32'hX; o_size = 2'bx; o_wr = 1'bx;
      cpu_req = 1'b1; cpu_wr = wr; cpu_size = size; cpu_addr = addr;
      cpu_wdata = wdata; pipe_adv = 1'b0; data_rdata = rdata;
      e.st = wr; e.rdata = rdata;
      sb_q.push_back(e);
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         #1;
         data_addr_ok = 1'b0;
         data_data_ok = 1'b0;
         if (data_req) begin
            reqc++;
            if (reqc > a_dly) begin
               data_addr_ok = 1'b1;
               data_data_ok = (d_dly == 0);
            end
         end else if (accepted) begin
            waitc++;
            data_data_ok = (waitc >= d_dly);
         end
         #1;
         if (data_req && first_req) begin
            o_addr = data_addr; o_wdata = data_wdata; o_size = data_size; o_wr = data_wr;
            first_req = 0;
         end
         if (data_req && data_addr_ok) accepted = 1;
         if (cpu_stall) o_stall++;
         else done = 1;
         if (!done) begin
            @(negedge clk);
            // The bus side must come from the request registers.
            if (cyc == 0) begin
               cpu_addr  = ~addr;
               cpu_wdata = ~wdata;
            end
         end
      end
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      o_reqc = reqc;
      if (!done) begin
         chk("txn_timeout", 32'd0, 32'd1);
      end else if (sb_q.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         if (!e.st) chk("sb_rdata", cpu_rdata, e.rdata);
      end
   endtask

   task automatic retire();
      pipe_adv = 1'b1;
      @(negedge clk);
      pipe_adv = 1'b0;
      #1;
      chk("idle_stall", cpu_stall, 1'b1);
      chk("idle_noreq", data_req, 1'b0);
      cpu_req = 1'b0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 2'd2, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000};
      vecs[1] = '{1'b1, 2'd0, 32'h0000_0203, 32'h0000_00A5, 32'h0000_0000, 32'hA5A5_A5A5};
      vecs[2] = '{1'b1, 2'd1, 32'h0000_0402, 32'h1234_BEEF, 32'h0000_0000, 32'hBEEF_BEEF};
      vecs[3] = '{1'b1, 2'd2, 32'h0000_0800, 32'hCAFE_F00D, 32'h0000_0000, 32'hCAFE_F00D};
      vecs[4] = '{1'b0, 2'd1, 32'h0000_0010, 32'h0000_0000, 32'h1122_3344, 32'h0000_0000};
      vecs[5] = '{1'b0, 2'd0, 32'h0000_0007, 32'h0000_00C3, 32'h5566_7788, 32'hC3C3_C3C3};
      vecs[6] = '{1'b1, 2'd3, 32'h0000_0020, 32'h89AB_CDEF, 32'h0000_0000, 32'h89AB_CDEF};

      rst = 1'b0; cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd2;
      cpu_addr = 32'h102; cpu_wdata = 32'h0; pipe_adv = 1'b0;
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;

      // Reset state, with an active-looking request and data_ok held high.
      @(negedge clk); @(negedge clk); #1;
      chk("rst_stall", cpu_stall, 1'b0);
      chk("rst_req",   data_req,  1'b0);
      chk("rst_adel",  cpu_adel,  1'b0);
      chk("rst_ades",  cpu_ades,  1'b0);
      chk("rst_rdata", cpu_rdata, 32'h0);
      chk("rst_addr",  data_addr, 32'h0);
      chk("rst_wdata", data_wdata, 32'h0);
      cpu_req = 1'b0; data_data_ok = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Table vectors with a same-cycle addr_ok/data_ok handshake.
      for (int i = 0; i < 7; i++) begin
         txn(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, 0, 0);
         chk($sformatf("v%0d_wdata", i), o_wdata, vecs[i].exp_wdata);
         chk($sformatf("v%0d_addr", i),  o_addr,  vecs[i].addr);
         chk($sformatf("v%0d_size", i),  {30'd0, o_size}, {30'd0, vecs[i].size});
         chk($sformatf("v%0d_wr", i),    o_wr,    vecs[i].wr);
         chk($sformatf("v%0d_stall", i), o_stall, 32'd2);
         chk($sformatf("v%0d_reqc", i),  o_reqc,  32'd1);
         retire();
      end

      // Slow bus: addr_ok after 3 cycles and data_ok 2 cycles later; then hold DONE.
      txn(1'b0, 2'd2, 32'h500, 32'h0, 32'h1357_9BDF, 3, 2);
      chk("slow_stall", o_stall, 32'd7);
      chk("slow_reqc",  o_reqc,  32'd4);
      data_rdata = 32'hFFFF_0000;
      data_data_ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         chk($sformatf("hold%0d_req", k),   data_req,  1'b0);
         chk($sformatf("hold%0d_stall", k), cpu_stall, 1'b0);
         chk($sformatf("hold%0d_rdata", k), cpu_rdata, 32'h1357_9BDF);
      end
      data_data_ok = 1'b0;
      retire();

      // Reset while in WAIT, then a stray data_ok.
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h300;
      data_rdata = 32'hA0A0_A0A0;
      @(negedge clk); #1;
      chk("w_req", data_req, 1'b1);
      data_addr_ok = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0;
      #1;
      chk("w_noreq", data_req,  1'b0);
      chk("w_stall", cpu_stall, 1'b1);
      rst = 1'b0;
      #1;
      chk("wr_stall", cpu_stall, 1'b0);
      chk("wr_req",   data_req,  1'b0);
      chk("wr_rdata", cpu_rdata, 32'h0);
      chk("wr_addr",  data_addr, 32'h0);
      chk("wr_wdata", data_wdata, 32'h0);
      chk("wr_size",  {30'd0, data_size}, 32'h0);
      chk("wr_wr",    data_wr,   1'b0);
      chk("wr_adel",  cpu_adel,  1'b0);
      chk("wr_ades",  cpu_ades,  1'b0);
      cpu_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      data_data_ok = 1'b0;
      #1;
      chk("stray_rdata", cpu_rdata, 32'h0);
      chk("stray_req",   data_req,  1'b0);
      cpu_req = 1'b1;
      #1;
      chk("stray_idle", cpu_stall, 1'b1);
      cpu_req = 1'b0;
      @(negedge clk);
      txn(1'b0, 2'd2, 32'h600, 32'h0, 32'h2468_ACE0, 1, 0);
      chk("post_rst_stall", o_stall, 32'd3);
      chk("post_rst_addr",  o_addr,  32'h600);
      retire();

      // Misaligned word load at 0x102.
`ifdef DMEM_BRIDGE_ALIGN_CHECK_EN
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h102;
      #1;
      chk("mis_adel",  cpu_adel,  1'b1);
      chk("mis_ades",  cpu_ades,  1'b0);
      chk("mis_stall", cpu_stall, 1'b0);
      chk("mis_req",   data_req,  1'b0);
      @(negedge clk); #1;
      chk("mis_req2",  data_req,  1'b0);
      chk("mis_adel2", cpu_adel,  1'b1);
      cpu_wr = 1'b1;
      #1;
      chk("mis_ades_st", cpu_ades, 1'b1);
      chk("mis_adel_st", cpu_adel, 1'b0);
      cpu_req = 1'b0;
      @(negedge clk);
`else
      txn(1'b0, 2'd2, 32'h102, 32'h0, 32'h2468_1357, 0, 0);
      chk("mis_addr",  o_addr,  32'h102);
      chk("mis_stall", o_stall, 32'd2);
      chk("mis_reqc",  o_reqc,  32'd1);
      chk("mis_adel",  cpu_adel, 1'b0);
      retire();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
